// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: holds the PC, issues one outstanding imem read at a
// time, and hands 16-bit instructions to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [3:0]        out_opcode,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  // state   | meaning
  // S_ISSUE | drive imem_req for one cycle at pc
  // S_WAIT  | request outstanding, capture response
  // S_HOLD  | instruction presented, wait for decode to accept
  // S_DRAIN | stale request outstanding after redirect, discard its response
  // S_HALT  | STOP accepted, fetch stopped until reset
  typedef enum logic [2:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_STOP = 4'b1111;

  state_t            state;
  logic [ADDR_W-1:0] pc;

  assign imem_req   = (state == S_ISSUE);
  assign imem_addr  = pc;
  assign out_opcode = out_instr[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ISSUE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_ISSUE: begin
          if (redirect_en) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_en) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= imem_valid ? S_ISSUE : S_DRAIN;
          end else if (imem_valid) begin
            out_instr <= imem_rdata;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + ADDR_W'(1);
            state     <= S_HOLD;
          end
        end

        S_HOLD: begin
          // A redirect flushes the held instruction even if it is being accepted.
          if (redirect_en) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= S_ISSUE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_opcode == OP_STOP) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        S_DRAIN: begin
          if (redirect_en) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end
          // The single stale request retires here; leaving on its response
          // avoids waiting forever for a second response that never comes.
          if (imem_valid) begin
            state <= S_ISSUE;
          end
        end

        S_HALT: begin
          out_valid <= 1'b0;
          halted    <= 1'b1;
        end

        default: state <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: instruction-memory model with configurable latency,
// scoreboard of expected (pc, instr) pairs popped on each accepted handshake.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [3:0]  out_opcode;
  logic [7:0]  out_pc;
  logic        halted;

  // second instance starting at the top of the address space
  logic        w_req;
  logic [7:0]  w_addr;
  logic        w_valid;
  logic [15:0] w_rdata;
  logic        w_out_valid;
  logic        w_ready;
  logic [15:0] w_instr;
  logic [3:0]  w_opcode;
  logic [7:0]  w_pc;
  logic        w_halted;
  logic        w_redirect_en;
  logic [7:0]  w_redirect_pc;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem[256];
  int          lat;
  int          pend_cnt;
  logic [7:0]  pend_addr;
  logic [7:0]  w_seen[2];
  int          w_cnt;
  int          chk_cnt;
  int          pass_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_opcode(out_opcode),
    .out_pc(out_pc), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(w_rdata),
    .redirect_en(w_redirect_en), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_ready),
    .out_instr(w_instr), .out_opcode(w_opcode),
    .out_pc(w_pc), .halted(w_halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: sample pre-edge, advance, then drive the memory models.
  task automatic tick();
    logic       rq, rst_q, wrq;
    logic [7:0] aq, waq;
    exp_t       e;
    rq = imem_req; aq = imem_addr; rst_q = rst; wrq = w_req; waq = w_addr;
    if (!rst && out_valid && out_ready) begin
      check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("out_pc", 32'(out_pc), 32'(e.pc));
        check_eq("out_instr", 32'(out_instr), 32'(e.instr));
        check_eq("out_opcode", 32'(out_opcode), 32'(e.instr[15:12]));
      end
    end
    if (!rst_q && wrq && w_cnt < 2) begin
      w_seen[w_cnt] = waq;
      w_cnt++;
    end
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
    if (rst_q) begin
      pend_cnt = 0;
    end else begin
      if (rq) begin
        pend_cnt  = lat;
        pend_addr = aq;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[pend_addr];
        end
      end
    end
    w_valid = wrq && !rst_q;
    w_rdata = 16'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_en = 1'b0; out_ready = 1'b0; lat = 1;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", 32'(out_instr), 32'd0);
    check_eq("rst_out_pc", 32'(out_pc), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd1);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int reqs;
    chk_cnt = 0; pass_cnt = 0; w_cnt = 0; pend_cnt = 0; pend_addr = '0;
    imem_valid = 1'b0; imem_rdata = '0; redirect_pc = '0;
    w_valid = 1'b0; w_rdata = '0; w_ready = 1'b1;
    w_redirect_en = 1'b0; w_redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0123; mem[8'h01] = 16'h1456; mem[8'h02] = 16'hF000;
    mem[8'h03] = 16'h7777; mem[8'h8A] = 16'h38A1; mem[8'h40] = 16'hF0AA;
    mem[8'h10] = 16'h5ABC;

    // straight-line fetch ending in STOP
    do_reset();
    out_ready = 1'b1;
    sb.push_back('{8'h00, 16'h0123});
    sb.push_back('{8'h01, 16'h1456});
    sb.push_back('{8'h02, 16'hF000});
    tick(); tick();
    check_eq("first_latency", 32'(out_valid), 32'd1);
    n = 0;
    while (!halted && n < 30) begin tick(); n++; end
    check_eq("halted", 32'(halted), 32'd1);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    redirect_en = 1'b1; redirect_pc = 8'h05;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      redirect_en = 1'b0;
      if (imem_req) reqs++;
    end
    check_eq("halt_no_req", 32'(reqs), 32'd0);
    check_eq("halt_sticky", 32'(halted), 32'd1);
    check_eq("halt_out_valid", 32'(out_valid), 32'd0);
    check_eq("wrap_first", 32'(w_seen[0]), 32'hFF);
    check_eq("wrap_second", 32'(w_seen[1]), 32'h00);

    // backpressure with 16'h2345 held
    mem[8'h00] = 16'h2345;
    do_reset();
    sb.push_back('{8'h00, 16'h2345});
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_instr", 32'(out_instr), 32'h2345);
      check_eq("bp_pc", 32'(out_pc), 32'h00);
      check_eq("bp_no_req", 32'(imem_req), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_next_req", 32'(imem_req), 32'd1);
    check_eq("bp_next_addr", 32'(imem_addr), 32'h01);
    check_eq("bp_sb_drained", 32'(sb.size()), 32'd0);

    // redirect while waiting on addr 3
    mem[8'h00] = 16'h0123; mem[8'h02] = 16'h2000;
    do_reset();
    out_ready = 1'b1;
    sb.push_back('{8'h00, 16'h0123});
    sb.push_back('{8'h01, 16'h1456});
    sb.push_back('{8'h02, 16'h2000});
    n = 0;
    while (!(imem_req && imem_addr == 8'h03) && n < 30) begin tick(); n++; end
    check_eq("rw_req3", 32'(imem_addr), 32'h03);
    lat = 3;
    tick();
    redirect_en = 1'b1; redirect_pc = 8'h8A;
    tick();
    redirect_en = 1'b0; lat = 1;
    check_eq("rw_drain_no_req", 32'(imem_req), 32'd0);
    tick();
    check_eq("rw_stale_valid", 32'(imem_valid), 32'd1);
    tick();
    check_eq("rw_req", 32'(imem_req), 32'd1);
    check_eq("rw_addr", 32'(imem_addr), 32'h8A);
    sb.push_back('{8'h8A, 16'h38A1});
    n = 0;
    while (sb.size() > 0 && n < 30) begin tick(); n++; end
    out_ready = 1'b0;
    check_eq("rw_sb_drained", 32'(sb.size()), 32'd0);

    // redirect in ISSUE, then redirect coincident with STOP accept
    do_reset();
    redirect_en = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_en = 1'b0;
    tick();
    check_eq("ri_addr", 32'(imem_addr), 32'h40);
    sb.push_back('{8'h40, 16'hF0AA});
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq("rs_opcode", 32'(out_opcode), 32'hF);
    out_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 8'h10;
    tick();
    out_ready = 1'b0; redirect_en = 1'b0;
    check_eq("rs_halted", 32'(halted), 32'd0);
    check_eq("rs_out_valid", 32'(out_valid), 32'd0);
    check_eq("rs_req", 32'(imem_req), 32'd1);
    check_eq("rs_addr", 32'(imem_addr), 32'h10);

    // one-cycle reset while holding an instruction
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq("rh_valid", 32'(out_valid), 32'd1);
    check_eq("rh_pc", 32'(out_pc), 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rh_out_valid", 32'(out_valid), 32'd0);
    check_eq("rh_halted", 32'(halted), 32'd0);
    check_eq("rh_req", 32'(imem_req), 32'd1);
    check_eq("rh_addr", 32'(imem_addr), 32'h00);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
